// File: rtl/bcd_time_keeper.sv
// BCD hh:mm:ss time-of-day counter advanced by synchronised tick_in edges, with a checked load.
// TIME_12H_DISPLAY_EN: present the hour field in 12-hour form and drive pm.
module bcd_time_keeper #(
  parameter int SYNC_STAGES   = 2,
  parameter int TICKS_PER_SEC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        run,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  output logic        set_err,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        hour_pulse,
  output logic        day_pulse,
  output logic        pm
);

  localparam int PW = $clog2(TICKS_PER_SEC) + 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {IDLE, CHECK} state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q, edge_w;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0] time_q, time_d, nxt, shadow_q;
  logic sec_q, min_q, hour_q, day_q, err_q;
  logic capture, commit, reject, shadow_ok;
  logic tick_w, wrap, adv;
  logic c_s, c_m, c_d, h_top;
  logic [3:0] s1, s10, m1, m10, h1, h10;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_w = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (set_valid) state_d = CHECK;
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    set_ready = (state_q == IDLE);
    capture   = (state_q == IDLE) & set_valid;
    commit    = (state_q == CHECK) & shadow_ok;
    reject    = (state_q == CHECK) & ~shadow_ok;
  end

  assign shadow_ok = (shadow_q[3:0]   <= 4'd9) && (shadow_q[7:4]   <= 4'd5)
                  && (shadow_q[11:8]  <= 4'd9) && (shadow_q[15:12] <= 4'd5)
                  && (shadow_q[19:16] <= 4'd9) && (shadow_q[23:20] <= 4'd2)
                  && !(shadow_q[23:20] == 4'd2 && shadow_q[19:16] > 4'd3);

  assign {h10, h1, m10, m1, s10, s1} = time_q;

  assign tick_w = edge_w & run;
  assign wrap   = (pre_q == PMAX);
  // A load commit overrides a coincident second advance.
  assign adv    = tick_w & wrap & ~commit;

  always_comb begin
    pre_d = pre_q;
    if (commit)      pre_d = '0;
    else if (tick_w) pre_d = wrap ? '0 : pre_q + PW'(1);
  end

  assign c_s   = (s10 == 4'd5) && (s1 == 4'd9);
  assign c_m   = c_s && (m10 == 4'd5) && (m1 == 4'd9);
  assign h_top = (h10 == 4'd2) && (h1 == 4'd3);
  assign c_d   = c_m && h_top;

  always_comb begin
    nxt = time_q;
    nxt[3:0] = (s1 == 4'd9) ? 4'd0 : s1 + 4'd1;
    if (s1 == 4'd9)
      nxt[7:4] = (s10 == 4'd5) ? 4'd0 : s10 + 4'd1;
    if (c_s)
      nxt[11:8] = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
    if (c_s && m1 == 4'd9)
      nxt[15:12] = (m10 == 4'd5) ? 4'd0 : m10 + 4'd1;
    if (c_m)
      nxt[19:16] = (h_top || h1 == 4'd9) ? 4'd0 : h1 + 4'd1;
    if (c_m)
      nxt[23:20] = h_top ? 4'd0 : (h1 == 4'd9) ? h10 + 4'd1 : h10;
  end

  always_comb begin
    time_d = time_q;
    if (commit)   time_d = shadow_q;
    else if (adv) time_d = nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_q   <= '0;
      pre_q    <= '0;
      shadow_q <= '0;
      sec_q    <= 1'b0;
      min_q    <= 1'b0;
      hour_q   <= 1'b0;
      day_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      time_q <= time_d;
      pre_q  <= pre_d;
      if (capture) shadow_q <= set_time;
      sec_q  <= adv;
      min_q  <= adv & c_s;
      hour_q <= adv & c_m;
      day_q  <= adv & c_d;
      err_q  <= reject;
    end
  end

  assign sec_pulse  = sec_q;
  assign min_pulse  = min_q;
  assign hour_pulse = hour_q;
  assign day_pulse  = day_q;
  assign set_err    = err_q;

`ifdef TIME_12H_DISPLAY_EN
  logic [6:0] hb, hd;
  assign hb = 7'(h10) * 7'd10 + 7'(h1);
  assign hd = (hb == 7'd0) ? 7'd12 : (hb > 7'd12) ? hb - 7'd12 : hb;
  assign pm = (hb >= 7'd12);
  assign time_bcd = {(hd >= 7'd10) ? 4'd1 : 4'd0,
                     (hd >= 7'd10) ? 4'(hd - 7'd10) : 4'(hd),
                     time_q[15:0]};
`else
  assign pm       = 1'b0;
  assign time_bcd = time_q;
`endif

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Randomised bench for bcd_time_keeper: two instances (1 and 4 ticks/second)
// checked every cycle against a seconds-of-day reference model.
module tb_bcd_time_keeper;

  localparam int S = 2;

  logic clock, reset, tick_in, run, set_valid;
  logic [23:0] set_time;
  logic        rdy_o[2], err_o[2], sec_o[2], min_o[2];
  logic        hr_o[2], day_o[2], pm_o[2];
  logic [23:0] tm_o[2];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bcd_time_keeper #(
      .SYNC_STAGES(S),
      .TICKS_PER_SEC(g == 0 ? 1 : 4)
    ) u_dut (
      .clock(clock), .reset(reset), .tick_in(tick_in), .run(run),
      .set_valid(set_valid), .set_ready(rdy_o[g]), .set_time(set_time),
      .set_err(err_o[g]), .time_bcd(tm_o[g]), .sec_pulse(sec_o[g]),
      .min_pulse(min_o[g]), .hour_pulse(hr_o[g]), .day_pulse(day_o[g]),
      .pm(pm_o[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  int          secs[2], pre[2];
  bit          busy[2];
  logic [23:0] shadow[2];
  bit          e_sec[2], e_min[2], e_hr[2], e_day[2], e_err[2];
  bit          hs[S+1];
  bit          m_edge, m_adv, m_com;

  function automatic int tps(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [23:0] s2b(int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit ok(logic [23:0] v);
    int hh, mm, ss;
    for (int i = 0; i < 6; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    hh = int'(v[23:20]) * 10 + int'(v[19:16]);
    mm = int'(v[15:12]) * 10 + int'(v[11:8]);
    ss = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (hh < 24) && (mm < 60) && (ss < 60);
  endfunction

  function automatic int b2s(logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600
         + (int'(v[15:12]) * 10 + int'(v[11:8])) * 60
         + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [23:0] disp(int s);
    logic [23:0] b;
    b = s2b(s);
`ifdef TIME_12H_DISPLAY_EN
    begin
      int h, hd;
      h  = s / 3600;
      hd = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
      b[23:16] = {4'(hd / 10), 4'(hd % 10)};
    end
`endif
    return b;
  endfunction

  function automatic bit exp_pm(int s);
`ifdef TIME_12H_DISPLAY_EN
    return s >= 43200;
`else
    return (s < 0);
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      secs[k] = 0; pre[k] = 0; busy[k] = 0; shadow[k] = '0;
      e_sec[k] = 0; e_min[k] = 0; e_hr[k] = 0; e_day[k] = 0; e_err[k] = 0;
    end
    for (int i = 0; i <= S; i++) hs[i] = 0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_edge = hs[S-1] & ~hs[S];
      for (int k = 0; k < 2; k++) begin
        m_adv = 0;
        if (m_edge && run) begin
          if (pre[k] == tps(k) - 1) begin pre[k] = 0; m_adv = 1; end
          else pre[k] = pre[k] + 1;
        end
        m_com    = busy[k] && ok(shadow[k]);
        e_err[k] = busy[k] && !ok(shadow[k]);
        if (m_com) begin secs[k] = b2s(shadow[k]); pre[k] = 0; m_adv = 0; end
        if (m_adv) secs[k] = (secs[k] + 1) % 86400;
        e_sec[k] = m_adv;
        e_min[k] = m_adv && (secs[k] % 60 == 0);
        e_hr[k]  = m_adv && (secs[k] % 3600 == 0);
        e_day[k] = m_adv && (secs[k] == 0);
        if (busy[k]) busy[k] = 0;
        else if (set_valid) begin busy[k] = 1; shadow[k] = set_time; end
      end
      for (int i = S; i > 0; i--) hs[i] = hs[i-1];
      hs[0] = tick_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("time%0d", k), 32'(tm_o[k]), 32'(disp(secs[k])));
      check($sformatf("sec%0d", k),  32'(sec_o[k]), 32'(e_sec[k]));
      check($sformatf("min%0d", k),  32'(min_o[k]), 32'(e_min[k]));
      check($sformatf("hour%0d", k), 32'(hr_o[k]),  32'(e_hr[k]));
      check($sformatf("day%0d", k),  32'(day_o[k]), 32'(e_day[k]));
      check($sformatf("err%0d", k),  32'(err_o[k]), 32'(e_err[k]));
      check($sformatf("rdy%0d", k),  32'(rdy_o[k]), 32'(!busy[k]));
      check($sformatf("pm%0d", k),   32'(pm_o[k]),  32'(exp_pm(secs[k])));
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick_pulse(input int hi, input int lo);
    tick_in = 1'b1; idle(hi);
    tick_in = 1'b0; idle(lo);
  endtask

  task automatic load(input logic [23:0] v);
    set_valid = 1'b1; set_time = v; idle(1);
    set_valid = 1'b0; idle(3);
  endtask

  // Commit lands on the same edge as an advance of the 1-tick instance.
  task automatic load_on_advance(input logic [23:0] v);
    tick_in = 1'b0; idle(4);
    tick_in = 1'b1; idle(1);
    set_valid = 1'b1; set_time = v; idle(1);
    set_valid = 1'b0; idle(4);
    tick_in = 1'b0; idle(3);
  endtask

  int near;

  initial begin
    reset = 1'b0; tick_in = 1'b0; run = 1'b1;
    set_valid = 1'b0; set_time = '0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick_in = ~tick_in; idle(1);
    end
    tick_in = 1'b0; idle(1);
    reset = 1'b1;
    idle(2);
    repeat (3) tick_pulse(3, 3);
    load(24'h235958);
    repeat (2) tick_pulse(2, 3);
    load(24'h246000);
    load(24'h095960);
    load(24'hA00000);
    load_on_advance(24'h115959);
    repeat (6) tick_pulse(2, 2);
    run = 1'b0;
    repeat (5) tick_pulse(2, 2);
    run = 1'b1;
    tick_pulse(20, 4);
    load(24'h000000);
    load(24'h130000);
    load(24'h120000);
    load(24'h125959);
    repeat (3) tick_pulse(2, 2);
    set_valid = 1'b1; set_time = 24'h050505; idle(5);
    set_valid = 1'b0; idle(2);
    set_time = 24'h101010; set_valid = 1'b1; idle(1);
    set_valid = 1'b0;
    reset = 1'b0; model_reset(); idle(3);
    reset = 1'b1; idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      run = ($urandom_range(0, 9) != 0);
      set_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: set_time = 24'($urandom());
        1: set_time = s2b($urandom_range(0, 86399));
        default: begin
          near = ($urandom_range(0, 23) * 3600 + 3599 - $urandom_range(0, 3) + 86400) % 86400;
          if ($urandom_range(0, 1) == 0) near = 86399 - $urandom_range(0, 3);
          set_time = s2b(near);
        end
      endcase
      idle(1);
    end
    set_valid = 1'b0;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
